// File: rtl/phy_tx_seqctrl.sv
// -----------------------------------------------------------------------------
// phy_tx_seqctrl
//
// Purpose:
//   Feeds 64b/66b blocks to a GT TX gearbox running in external-sequence mode.
//   A free-running slot counter drives the GT sequence input; the last slot
//   of every period is the gearbox pause slot, where the GT ignores its data
//   inputs and the user side is stalled. After enable, a fixed number of idle
//   blocks is sent before user words are accepted. User words with an illegal
//   sync header are replaced by the idle block and counted.
//
// Ports:
//   i_clk          in   1   single clock for all logic
//   i_rst_n        in   1   asynchronous active-low reset
//   i_tx_en        in   1   transmit enable
//   i_data         in   64  user block payload
//   i_header       in   2   user sync header
//   i_valid        in   1   user word valid
//   o_ready        out  1   a user word can be accepted this cycle
//   o_gt_data      out  64  payload to the GT TX gearbox
//   o_gt_header    out  2   header to the GT TX gearbox
//   o_gt_sequence  out  7   sequence counter value to the GT
//   o_tx_active    out  1   high while running
//   o_hdr_err      out  1   one-cycle pulse when an illegal header is replaced
//   o_hdr_err_cnt  out  16  saturating count of illegal headers
// -----------------------------------------------------------------------------
module phy_tx_seqctrl #(
   parameter int          P_SEQ_MAX    = 32,
   parameter int          P_INIT_IDLE  = 16,
   parameter logic [63:0] P_IDLE_BLOCK = 64'h0000_0000_0000_001E
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_tx_en,
   input  logic [63:0] i_data,
   input  logic [1:0]  i_header,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [63:0] o_gt_data,
   output logic [1:0]  o_gt_header,
   output logic [6:0]  o_gt_sequence,
   output logic        o_tx_active,
   output logic        o_hdr_err,
   output logic [15:0] o_hdr_err_cnt
);

   localparam int LP_INIT_W = (P_INIT_IDLE > 1) ? $clog2(P_INIT_IDLE) : 1;
   localparam logic [LP_INIT_W-1:0] LP_INIT_LAST = LP_INIT_W'(P_INIT_IDLE - 1);
   localparam logic [6:0] LP_SEQ_MAX = 7'(P_SEQ_MAX);
   localparam logic [1:0] LP_IDLE_HDR = 2'b10;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t                 r_state;
   state_t                 w_nextState;
   logic [6:0]             r_seq;
   logic [LP_INIT_W-1:0]   r_initCnt;
   logic [LP_INIT_W-1:0]   w_nextInitCnt;
   logic [63:0]            r_gtData;
   logic [1:0]             r_gtHeader;
   logic [6:0]             r_gtSequence;
   logic                   r_hdrErr;
   logic [15:0]            r_hdrErrCnt;
   logic                   w_pause;
   logic                   w_ready;
   logic                   w_xfer;
   logic                   w_hdrIllegal;

   // The pause slot is the last value of the slot counter; the gearbox ignores
   // data there, so the user side is stalled and the outputs simply hold.
   // Only 01 and 10 are legal 64b/66b sync headers.
   assign w_pause      = (r_seq == LP_SEQ_MAX);
   assign w_ready      = (r_state == ST_RUN) && !w_pause && i_tx_en;
   assign w_xfer       = i_valid && w_ready;
   assign w_hdrIllegal = (i_header == 2'b00) || (i_header == 2'b11);

   assign o_ready       = w_ready;
   assign o_tx_active   = (r_state == ST_RUN);
   assign o_gt_data     = r_gtData;
   assign o_gt_header   = r_gtHeader;
   assign o_gt_sequence = r_gtSequence;
   assign o_hdr_err     = r_hdrErr;
   assign o_hdr_err_cnt = r_hdrErrCnt;

   // Free-running slot counter. It keeps counting whatever the state or the
   // enable is doing, so the GT always sees an unbroken sequence.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_seq <= '0;
      end else if (w_pause) begin
         r_seq <= '0;
      end else begin
         r_seq <= r_seq + 7'd1;
      end
   end

   // State and init-counter registers for the INIT/RUN controller.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_INIT;
         r_initCnt <= '0;
      end else begin
         r_state   <= w_nextState;
         r_initCnt <= w_nextInitCnt;
      end
   end

   // INIT counts enabled non-pause slots (each of which carries an idle
   // block) and moves to RUN on the last one. Losing enable at any point
   // throws away the progress, so a fresh enable always restarts the full
   // idle preamble.
   always_comb begin
      w_nextState   = r_state;
      w_nextInitCnt = r_initCnt;
      case (r_state)
         ST_INIT: begin
            if (!i_tx_en) begin
               w_nextInitCnt = '0;
            end else if (!w_pause) begin
               if (r_initCnt == LP_INIT_LAST) begin
                  w_nextState   = ST_RUN;
                  w_nextInitCnt = '0;
               end else begin
                  w_nextInitCnt = r_initCnt + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (!i_tx_en) begin
               w_nextState   = ST_INIT;
               w_nextInitCnt = '0;
            end
         end
         default: begin
            w_nextState   = ST_INIT;
            w_nextInitCnt = '0;
         end
      endcase
   end

   // GT output registers. Every non-pause slot carries either the accepted
   // user word or an idle block; in INIT and on underrun no transfer can
   // happen, so the idle block falls out naturally. Illegal headers are
   // swapped for idle so the link never sees a corrupt block.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_gtData     <= P_IDLE_BLOCK;
         r_gtHeader   <= LP_IDLE_HDR;
         r_gtSequence <= '0;
         r_hdrErr     <= 1'b0;
      end else begin
         r_gtSequence <= r_seq;
         r_hdrErr     <= w_xfer && w_hdrIllegal;
         if (!w_pause) begin
            if (w_xfer && !w_hdrIllegal) begin
               r_gtData   <= i_data;
               r_gtHeader <= i_header;
            end else begin
               r_gtData   <= P_IDLE_BLOCK;
               r_gtHeader <= LP_IDLE_HDR;
            end
         end
      end
   end

   // Saturating illegal-header counter; it sticks at all-ones rather than
   // wrapping so a long-running fault can never look like a clean link.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hdrErrCnt <= '0;
      end else if (w_xfer && w_hdrIllegal && (r_hdrErrCnt != 16'hFFFF)) begin
         r_hdrErrCnt <= r_hdrErrCnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_phy_tx_seqctrl.sv
// -----------------------------------------------------------------------------
// tb_phy_tx_seqctrl
//
// Self-checking bench for phy_tx_seqctrl. A behavioural model derives the
// slot number from the cycle count since reset, tracks run/idle progress as
// plain integers, and predicts every registered output; the main process
// compares the DUT against it on every cycle, alongside directed scenarios
// with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_phy_tx_seqctrl;

   localparam int          P_SEQ_MAX    = 32;
   localparam int          P_INIT_IDLE  = 16;
   localparam logic [63:0] IDLE         = 64'h0000_0000_0000_001E;

   logic        clk;
   logic        rst_n;
   logic        txEn;
   logic [63:0] data;
   logic [1:0]  hdr;
   logic        valid;
   logic        o_ready;
   logic [63:0] o_gt_data;
   logic [1:0]  o_gt_header;
   logic [6:0]  o_gt_sequence;
   logic        o_tx_active;
   logic        o_hdr_err;
   logic [15:0] o_hdr_err_cnt;

   int total;
   int bad;

   // Behavioural model state.
   int          mCycles;
   bit          mRun;
   int          mIdles;
   logic [63:0] eData;
   logic [1:0]  eHdr;
   int          eSeq;
   bit          eErr;
   int          eCnt;

   // Directed-scenario helpers.
   bit          lastAccept;
   bit          streamChk;
   int          wordsSeen;
   int          prevSeq;

   phy_tx_seqctrl #(
      .P_SEQ_MAX   (P_SEQ_MAX),
      .P_INIT_IDLE (P_INIT_IDLE),
      .P_IDLE_BLOCK(IDLE)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_tx_en      (txEn),
      .i_data       (data),
      .i_header     (hdr),
      .i_valid      (valid),
      .o_ready      (o_ready),
      .o_gt_data    (o_gt_data),
      .o_gt_header  (o_gt_header),
      .o_gt_sequence(o_gt_sequence),
      .o_tx_active  (o_tx_active),
      .o_hdr_err    (o_hdr_err),
      .o_hdr_err_cnt(o_hdr_err_cnt)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: bumps the counters and reports any difference.
   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   // Model reset: everything back to the documented reset values.
   task automatic modelReset();
      mCycles = 0;
      mRun    = 1'b0;
      mIdles  = 0;
      eData   = IDLE;
      eHdr    = 2'b10;
      eSeq    = 0;
      eErr    = 1'b0;
      eCnt    = 0;
   endtask

   // Model clock edge: slot number is the cycle count modulo the period;
   // compute what the GT outputs become and how the run/idle progress moves.
   task automatic modelEdge();
      int  slot;
      bit  pause;
      bit  rdy;
      slot  = mCycles % (P_SEQ_MAX + 1);
      pause = (slot == P_SEQ_MAX);
      rdy   = mRun && !pause && txEn;
      eSeq  = slot;
      eErr  = 1'b0;
      if (!pause) begin
         if (rdy && valid && (hdr == 2'b01 || hdr == 2'b10)) begin
            eData = data;
            eHdr  = hdr;
         end else begin
            eData = IDLE;
            eHdr  = 2'b10;
            if (rdy && valid) begin
               eErr = 1'b1;
               if (eCnt < 65535) eCnt++;
            end
         end
      end
      if (!mRun) begin
         if (!txEn) mIdles = 0;
         else if (!pause) begin
            mIdles++;
            if (mIdles == P_INIT_IDLE) begin
               mRun   = 1'b1;
               mIdles = 0;
            end
         end
      end else if (!txEn) begin
         mRun   = 1'b0;
         mIdles = 0;
      end
      mCycles++;
   endtask

   // Compare every registered output against the model, plus the stream
   // ordering and wrap checks while a counter stream is running.
   task automatic checkOutput();
      checkVal("gt_data", o_gt_data, eData);
      checkVal("gt_header", {62'd0, o_gt_header}, {62'd0, eHdr});
      checkVal("gt_sequence", {57'd0, o_gt_sequence}, 64'(eSeq));
      checkVal("hdr_err", {63'd0, o_hdr_err}, {63'd0, eErr});
      checkVal("hdr_err_cnt", {48'd0, o_hdr_err_cnt}, 64'(eCnt));
      checkVal("tx_active", {63'd0, o_tx_active}, {63'd0, mRun});
      if (streamChk) begin
         if (prevSeq == P_SEQ_MAX)
            checkVal("seq_wrap", {57'd0, o_gt_sequence}, 64'd0);
         if (o_gt_header == 2'b01 && o_gt_sequence != 7'(P_SEQ_MAX)) begin
            checkVal("stream_order", o_gt_data, {32'hC0DE_0000, 32'(wordsSeen)});
            wordsSeen++;
         end
         prevSeq = int'(o_gt_sequence);
      end
   endtask

   // One clock cycle: inputs are already driven; check the combinational
   // ready, advance the model, then sample the outputs on the falling edge.
   task automatic applyStimulus();
      int slot;
      bit expReady;
      #1;
      slot     = mCycles % (P_SEQ_MAX + 1);
      expReady = mRun && (slot != P_SEQ_MAX) && txEn;
      checkVal("ready", {63'd0, o_ready}, {63'd0, expReady});
      if (streamChk && slot == P_SEQ_MAX)
         checkVal("ready_pause", {63'd0, o_ready}, 64'd0);
      lastAccept = valid && o_ready;
      modelEdge();
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   // Reset assertion away from any clock edge, with immediate output check.
   task automatic assertReset();
      rst_n = 1'b0;
      modelReset();
      #1;
      checkVal("rst_ready", {63'd0, o_ready}, 64'd0);
      checkVal("rst_data", o_gt_data, IDLE);
      checkVal("rst_header", {62'd0, o_gt_header}, 64'd2);
      checkVal("rst_sequence", {57'd0, o_gt_sequence}, 64'd0);
      checkVal("rst_active", {63'd0, o_tx_active}, 64'd0);
      checkVal("rst_err", {63'd0, o_hdr_err}, 64'd0);
      checkVal("rst_cnt", {48'd0, o_hdr_err_cnt}, 64'd0);
   endtask

   initial begin
      int sent;
      int nonPause;
      int guard;
      bit seen;

      total = 0;
      bad = 0;
      streamChk = 1'b0;
      wordsSeen = 0;
      prevSeq = -1;
      txEn = 1'b1;
      valid = 1'b1;
      data = {32'hC0DE_0000, 32'd0};
      hdr = 2'b01;
      rst_n = 1'b1;

      // Reset with enable and valid already up.
      @(negedge clk);
      assertReset();
      repeat (3) @(negedge clk);
      checkVal("rst_hold_seq", {57'd0, o_gt_sequence}, 64'd0);
      rst_n = 1'b1;

      // Startup and counter stream across several pause slots.
      $display("[TB] startup and streaming");
      streamChk = 1'b1;
      sent = 0;
      nonPause = 0;
      seen = 1'b0;
      for (int k = 0; k < 140; k++) begin
         data = {32'hC0DE_0000, 32'(sent)};
         #1;
         if (!seen && o_ready) begin
            seen = 1'b1;
            checkVal("startup_idles", 64'(nonPause), 64'(P_INIT_IDLE));
            checkVal("startup_active", {63'd0, o_tx_active}, 64'd1);
         end
         if (!seen && (mCycles % (P_SEQ_MAX + 1)) != P_SEQ_MAX) nonPause++;
         applyStimulus();
         if (lastAccept) sent++;
      end
      if (!seen) checkVal("startup_timeout", 64'd0, 64'd1);
      checkVal("stream_count", 64'(wordsSeen), 64'(sent));
      streamChk = 1'b0;

      // Underrun: three RUN slots with no valid, starting well clear of the pause.
      $display("[TB] underrun");
      valid = 1'b0;
      guard = 0;
      while ((mCycles % (P_SEQ_MAX + 1)) != 3 && guard < 100) begin
         applyStimulus();
         guard++;
      end
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkVal("underrun_data", o_gt_data, 64'h0000_0000_0000_001E);
         checkVal("underrun_hdr", {62'd0, o_gt_header}, 64'd2);
      end

      // Single illegal header.
      $display("[TB] illegal header");
      valid = 1'b1;
      hdr = 2'b11;
      data = 64'hDEAD_BEEF_0000_0001;
      guard = 0;
      lastAccept = 1'b0;
      while (!lastAccept && guard < 40) begin
         applyStimulus();
         guard++;
      end
      if (!lastAccept) checkVal("illegal_timeout", 64'd0, 64'd1);
      checkVal("illegal_err", {63'd0, o_hdr_err}, 64'd1);
      checkVal("illegal_cnt", {48'd0, o_hdr_err_cnt}, 64'd1);
      checkVal("illegal_data", o_gt_data, 64'h1E);
      valid = 1'b0;
      hdr = 2'b01;
      applyStimulus();
      checkVal("illegal_pulse_end", {63'd0, o_hdr_err}, 64'd0);

      // Disable for one cycle, then the full idle preamble is needed again.
      $display("[TB] disable");
      txEn = 1'b0;
      applyStimulus();
      checkVal("disable_active", {63'd0, o_tx_active}, 64'd0);
      txEn = 1'b1;
      valid = 1'b1;
      nonPause = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         #1;
         if (o_ready) begin
            seen = 1'b1;
            checkVal("reenable_idles", 64'(nonPause), 64'(P_INIT_IDLE));
         end else begin
            if ((mCycles % (P_SEQ_MAX + 1)) != P_SEQ_MAX) nonPause++;
            applyStimulus();
         end
      end
      if (!seen) checkVal("reenable_timeout", 64'd0, 64'd1);

      // Randomized traffic with occasional enable drops and bad headers.
      $display("[TB] random traffic");
      for (int k = 0; k < 1500; k++) begin
         txEn  = ($urandom_range(0, 49) != 0);
         valid = ($urandom_range(0, 3) != 0);
         data  = {$urandom, $urandom};
         if ($urandom_range(0, 9) == 0) hdr = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
         else hdr = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
         applyStimulus();
      end

      // Drive illegal headers until the counter must have saturated.
      $display("[TB] error counter saturation");
      txEn = 1'b1;
      valid = 1'b1;
      hdr = 2'b11;
      guard = 0;
      while (eCnt < 65535 && guard < 80000) begin
         data = {$urandom, $urandom};
         applyStimulus();
         guard++;
      end
      if (eCnt < 65535) checkVal("saturate_timeout", 64'd0, 64'd1);
      repeat (5) applyStimulus();
      checkVal("saturate_cnt", {48'd0, o_hdr_err_cnt}, 64'hFFFF);

      // Mid-run reset when the slot counter is at 20.
      $display("[TB] mid-run reset");
      hdr = 2'b01;
      guard = 0;
      while ((mCycles % (P_SEQ_MAX + 1)) != 20 && guard < 100) begin
         applyStimulus();
         guard++;
      end
      checkVal("midrun_seq19", {57'd0, o_gt_sequence}, 64'd19);
      checkVal("midrun_running", {63'd0, o_tx_active}, 64'd1);
      #2;
      assertReset();
      @(negedge clk);
      checkVal("midrun_hold_seq", {57'd0, o_gt_sequence}, 64'd0);
      rst_n = 1'b1;
      applyStimulus();
      checkVal("restart_seq0", {57'd0, o_gt_sequence}, 64'd0);
      applyStimulus();
      checkVal("restart_seq1", {57'd0, o_gt_sequence}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phy_tx_seqctrl.md
PHY_TX_SEQCTRL -- requirements
Module: PHY_tx_seqctrl

Interface
REQ-001 SHALL have parameter P_SEQ_MAX, default 32, meaning the last sequence value; that slot is the gearbox pause slot.
REQ-002 SHALL have parameter P_INIT_IDLE, default 16, meaning the number of idle blocks sent after enable before user data is accepted.
REQ-003 SHALL have parameter P_IDLE_BLOCK, default 64'h0000_0000_0000_001E, meaning the idle control block payload; it is sent with header 2'b10.
REQ-004 SHALL have port i_clk  input  1  single clock for all logic.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_tx_en  input  1  transmit enable.
REQ-007 SHALL have port i_data  input  64  user block payload.
REQ-008 SHALL have port i_header  input  2  user sync header.
REQ-009 SHALL have port i_valid  input  1  user word valid.
REQ-010 SHALL have port o_ready  output  1  block can accept a user word this cycle.
REQ-011 SHALL have port o_gt_data  output  64  payload to the GT TX gearbox.
REQ-012 SHALL have port o_gt_header  output  2  header to the GT TX gearbox.
REQ-013 SHALL have port o_gt_sequence  output  7  external sequence counter value to the GT.
REQ-014 SHALL have port o_tx_active  output  1  high while in the RUN state.
REQ-015 SHALL have port o_hdr_err  output  1  one-cycle pulse when an accepted word carries an illegal header.
REQ-016 SHALL have port o_hdr_err_cnt  output  16  saturating count of illegal headers.

Function
REQ-017 SHALL keep a free-running slot counter r_seq: +1 every cycle, wrapping P_SEQ_MAX -> 0, independent of state and of i_tx_en.
REQ-018 SHALL register every GT output on i_clk, so each output is valid 1 cycle after its slot.
REQ-019 SHALL load o_gt_sequence with the r_seq value of the slot on every cycle.
REQ-020 SHALL treat a slot with r_seq == P_SEQ_MAX as a pause slot: o_gt_data and o_gt_header hold their previous values, and o_ready = 0.
REQ-021 SHALL implement two states. INIT is the reset state. RUN is entered from INIT when the init counter reaches P_INIT_IDLE-1 on a non-pause slot with i_tx_en = 1.
REQ-022 SHALL, in INIT, increment the init counter on each non-pause slot with i_tx_en = 1, clear it when i_tx_en = 0, send the idle block on non-pause slots, and hold o_ready = 0.
REQ-023 SHALL, in RUN, return to INIT at the next edge when i_tx_en = 0, with the init counter cleared; a word accepted on that same cycle is still transmitted.
REQ-024 SHALL drive o_ready = (state == RUN) && (r_seq != P_SEQ_MAX) && i_tx_en; o_ready SHALL NOT depend on i_valid.
REQ-025 SHALL transfer a word only when i_valid && o_ready; the word appears on o_gt_data/o_gt_header on the next cycle.
REQ-026 SHALL send the idle block with header 2'b10 on any non-pause RUN slot with no transfer (underrun fill).
REQ-027 SHALL replace a transferred word whose header is 2'b00 or 2'b11 with the idle block and header 2'b10, and pulse o_hdr_err on the cycle the replacement appears on the outputs.
REQ-028 SHALL increment o_hdr_err_cnt once per illegal header and saturate it at 16'hFFFF.
REQ-029 SHALL drive o_tx_active from the registered state (1 in RUN).
REQ-030 SHALL never drop or duplicate an accepted word; an i_valid word held across a pause slot SHALL be accepted on the next slot.

Reset
REQ-031 SHALL, while i_rst_n = 0, force: state INIT, r_seq = 0, init counter = 0, o_gt_sequence = 0, o_gt_data = P_IDLE_BLOCK, o_gt_header = 2'b10, o_ready = 0, o_tx_active = 0, o_hdr_err = 0, o_hdr_err_cnt = 0.
REQ-032 SHALL take effect immediately on assertion of reset, including mid-transfer; a word presented in that cycle is discarded. Release SHALL be sampled on i_clk.

Verification
REQ-033 SHALL be verified for startup: reset release with i_tx_en = 1 and i_valid = 1 gives 16 idle blocks on non-pause slots, then o_ready = 1 and o_tx_active = 1.
REQ-034 SHALL be verified for the pause slot: streaming data must show o_gt_sequence 0..32 wrapping to 0, o_ready = 0 in slot 32, output held in slot 32, and no lost words (counter pattern checked end-to-end).
REQ-035 SHALL be verified for underrun: i_valid = 0 for 3 RUN slots gives 3 blocks of 64'h...001E with header 2'b10.
REQ-036 SHALL be verified for illegal headers: a word with header 2'b11 gives the idle block, o_hdr_err = 1 for one cycle and o_hdr_err_cnt = 1; forcing 65536 errors leaves the counter at 16'hFFFF.
REQ-037 SHALL be verified for disable: dropping i_tx_en in RUN gives INIT next cycle, o_ready = 0 and idles; re-enabling requires 16 further idles.
REQ-038 SHALL be verified for mid-run reset: asserting i_rst_n = 0 at r_seq = 20 gives all outputs at their REQ-031 values asynchronously, and o_gt_sequence restarts at 0 after release.
